// File: rtl/crossyroad_pkg.sv
// crossyroad_pkg
// Shared definitions for the crossyroad game-flow sequencer: the game_state
// encoding, the lane-pattern LFSR seed and taps, the speed ceiling, and small
// helpers for the LFSR step and the speed mapping.
package crossyroad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCROLL = 2'd2,
        ST_DEAD   = 2'd3
    } game_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps on bits 7,5,4,3 (x^8+x^6+x^5+x^4+1).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [1:0] SPEED_MAX = 2'd3;

    // Fibonacci shift-left step. A nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Speed level is score/8, capped at SPEED_MAX.
    function automatic logic [1:0] speed_of(input logic [7:0] sc);
        if ((sc >> 3) >= 8'(SPEED_MAX))
            return SPEED_MAX;
        else
            return sc[4:3];
    endfunction

endpackage

// File: rtl/crossyroad_game_ctrl_btn_debounce.sv
// btn_debounce
// Conditions a raw asynchronous push button: 2-FF synchronizer, then a
// stability counter, then a rising-edge detector on the debounced level.
//   clk       in  system clock
//   rst_man   in  asynchronous active-high reset
//   raw_in    in  raw button, active-high
//   level_out out debounced button level
//   press_out out one-clk pulse on each debounced rising edge
// Raw edge to press_out: 2 sync clocks + DB_CYCLES + 1.
module btn_debounce #(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_man,
    input  logic raw_in,
    output logic level_out,
    output logic press_out
);

    logic        sync_1;
    logic        sync_2;
    logic        level_d;
    logic [15:0] stable_cnt;

    always_ff @(posedge clk or posedge rst_man) begin
        if (rst_man) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw_in;
            sync_2 <= sync_1;
        end
    end

    // The counter tracks how many consecutive clocks the synchronized input
    // has disagreed with the debounced level; any agreement restarts it.
    always_ff @(posedge clk or posedge rst_man) begin
        if (rst_man) begin
            level_out  <= 1'b0;
            stable_cnt <= 16'd0;
        end else if (sync_2 != level_out) begin
            if (stable_cnt == DB_CYCLES - 16'd1) begin
                level_out  <= sync_2;
                stable_cnt <= 16'd0;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end else begin
            stable_cnt <= 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst_man) begin
        if (rst_man) begin
            level_d   <= 1'b0;
            press_out <= 1'b0;
        end else begin
            level_d   <= level_out;
            press_out <= level_out & ~level_d;
        end
    end

endmodule

// File: rtl/crossyroad_game_ctrl.sv
// crossyroad_game_ctrl
// Game-flow sequencer: debounces the move button, runs the
// IDLE/PLAY/SCROLL/DEAD state machine and animates a lane scroll one step
// per video frame. All outputs are registered.
//   clk           in  system/pixel clock
//   rst_man       in  asynchronous active-high reset
//   move_btn      in  raw move button, active-high
//   frame_tick    in  one-clk pulse per frame
//   collision     in  overlap flag, meaningful when frame_tick is high
//   game_state    out 0=IDLE 1=PLAY 2=SCROLL 3=DEAD
//   scroll_offset out vertical scroll in pixels
//   lane_shift    out one-clk pulse when a lane scroll completes
//   score         out lanes crossed, saturating at 255
//   speed         out min(3, score>>3), one clock behind score
//   lane_seed     out LFSR value for the next lane pattern
module crossyroad_game_ctrl
    import crossyroad_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES   = 16'd50000,
    parameter int          LANE_PX     = 32,
    parameter int          STEP_PX     = 4,
    parameter int          DEAD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_man,
    input  logic       move_btn,
    input  logic       frame_tick,
    input  logic       collision,
    output logic [1:0] game_state,
    output logic [4:0] scroll_offset,
    output logic       lane_shift,
    output logic [7:0] score,
    output logic [1:0] speed,
    output logic [7:0] lane_seed
);

    localparam logic [4:0] OFF_LAST  = 5'(LANE_PX - STEP_PX);
    localparam logic [4:0] OFF_STEP  = 5'(STEP_PX);
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_FRAMES - 1);

    logic btn_level;
    logic btn_press;
    logic press;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .rst_man   (rst_man),
        .raw_in    (move_btn),
        .level_out (btn_level),
        .press_out (btn_press)
    );

    // press_out only fires while the debounced level is high; qualifying on
    // the level keeps the FSM from acting on a press the debouncer has
    // already withdrawn.
    assign press = btn_press & btn_level;

    game_state_t state_q, state_n;
    logic [4:0]  offset_q, offset_n;
    logic        shift_q, shift_n;
    logic [7:0]  score_q, score_n;
    logic [7:0]  seed_q, seed_n;
    logic [7:0]  dead_cnt_q, dead_cnt_n;
    logic [1:0]  speed_q;

    always_ff @(posedge clk or posedge rst_man) begin
        if (rst_man) begin
            state_q    <= ST_IDLE;
            offset_q   <= 5'd0;
            shift_q    <= 1'b0;
            score_q    <= 8'd0;
            seed_q     <= LFSR_SEED;
            dead_cnt_q <= 8'd0;
            speed_q    <= 2'd0;
        end else begin
            state_q    <= state_n;
            offset_q   <= offset_n;
            shift_q    <= shift_n;
            score_q    <= score_n;
            seed_q     <= seed_n;
            dead_cnt_q <= dead_cnt_n;
            speed_q    <= speed_of(score_q);
        end
    end

    always_comb begin
        state_n    = state_q;
        offset_n   = offset_q;
        shift_n    = 1'b0;
        score_n    = score_q;
        seed_n     = seed_q;
        dead_cnt_n = dead_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_n  = ST_PLAY;
                    score_n  = 8'd0;
                    offset_n = 5'd0;
                end
            end

            ST_PLAY: begin
                // A fatal frame outranks a move requested in the same clock.
                if (frame_tick && collision) begin
                    state_n    = ST_DEAD;
                    dead_cnt_n = 8'd0;
                end else if (press) begin
                    state_n  = ST_SCROLL;
                    offset_n = 5'd0;
                end
            end

            ST_SCROLL: begin
                if (frame_tick) begin
                    if (collision) begin
                        state_n    = ST_DEAD;
                        dead_cnt_n = 8'd0;
                    end else if (offset_q == OFF_LAST) begin
                        state_n  = ST_PLAY;
                        offset_n = 5'd0;
                        shift_n  = 1'b1;
                        score_n  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        seed_n   = lfsr_next(seed_q);
                    end else begin
                        offset_n = offset_q + OFF_STEP;
                    end
                end
            end

            ST_DEAD: begin
                if (frame_tick) begin
                    if (dead_cnt_q == DEAD_LAST)
                        state_n = ST_IDLE;
                    else
                        dead_cnt_n = dead_cnt_q + 8'd1;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    assign game_state    = state_q;
    assign scroll_offset = offset_q;
    assign lane_shift    = shift_q;
    assign score         = score_q;
    assign speed         = speed_q;
    assign lane_seed     = seed_q;

endmodule

// File: tb/tb_crossyroad_game_ctrl.sv
module tb_crossyroad_game_ctrl;

    localparam logic [15:0] DB   = 16'd4;
    localparam int          DEAD = 3;

    logic       clk = 1'b0;
    logic       rst_man;
    logic       move_btn;
    logic       frame_tick;
    logic       collision;
    logic [1:0] game_state;
    logic [4:0] scroll_offset;
    logic       lane_shift;
    logic [7:0] score;
    logic [1:0] speed;
    logic [7:0] lane_seed;

    int checks   = 0;
    int failures = 0;
    logic [7:0] seed_m;

    crossyroad_game_ctrl #(
        .DB_CYCLES   (DB),
        .LANE_PX     (32),
        .STEP_PX     (4),
        .DEAD_FRAMES (DEAD)
    ) dut (
        .clk           (clk),
        .rst_man       (rst_man),
        .move_btn      (move_btn),
        .frame_tick    (frame_tick),
        .collision     (collision),
        .game_state    (game_state),
        .scroll_offset (scroll_offset),
        .lane_shift    (lane_shift),
        .score         (score),
        .speed         (speed),
        .lane_seed     (lane_seed)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout state=%0d", game_state);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [1:0] model_speed(input int sc);
        return (sc >= 24) ? 2'd3 : 2'(sc / 8);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick(input logic c);
        frame_tick = 1'b1;
        collision  = c;
        step();
        frame_tick = 1'b0;
        collision  = 1'b0;
    endtask

    task automatic press_btn();
        move_btn = 1'b1;
        steps(10);
        move_btn = 1'b0;
        steps(10);
    endtask

    task automatic test_reset();
        rst_man = 1'b1; move_btn = 1'b0; frame_tick = 1'b0; collision = 1'b0;
        steps(3);
        checks++;
        if (game_state !== 2'd0 || scroll_offset !== 5'd0 || lane_shift !== 1'b0 ||
            score !== 8'd0 || speed !== 2'd0 || lane_seed !== 8'hA5) begin
            failures++;
            $display("FAIL reset_values state=%0d off=%0d shift=%0d score=%0d speed=%0d seed=%h exp 0 0 0 0 0 a5",
                     game_state, scroll_offset, lane_shift, score, speed, lane_seed);
        end
        rst_man = 1'b0;
        step();
        press_btn();
        press_btn();
        tick(1'b0);
        tick(1'b0);
        checks++;
        if (game_state !== 2'd2 || scroll_offset !== 5'd8) begin
            failures++;
            $display("FAIL pre_reset_scroll state=%0d off=%0d exp 2 8", game_state, scroll_offset);
        end
        #2 rst_man = 1'b1;
        #1;
        checks++;
        if (game_state !== 2'd0 || scroll_offset !== 5'd0 || score !== 8'd0 || lane_seed !== 8'hA5) begin
            failures++;
            $display("FAIL async_reset state=%0d off=%0d score=%0d seed=%h exp 0 0 0 a5",
                     game_state, scroll_offset, score, lane_seed);
        end
        #1 rst_man = 1'b0;
        step();
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        checks++;
        if (game_state !== 2'd0 || scroll_offset !== 5'd0 || score !== 8'd0) begin
            failures++;
            $display("FAIL idle_ticks state=%0d off=%0d score=%0d exp 0 0 0", game_state, scroll_offset, score);
        end
    endtask

    task automatic test_debounce();
        move_btn = 1'b1;
        steps(3);
        move_btn = 1'b0;
        steps(12);
        checks++;
        if (game_state !== 2'd0) begin
            failures++;
            $display("FAIL glitch_ignored state=%0d exp 0", game_state);
        end
        move_btn = 1'b1;
        steps(7);
        checks++;
        if (game_state !== 2'd0) begin
            failures++;
            $display("FAIL press_early state=%0d exp 0", game_state);
        end
        step();
        checks++;
        if (game_state !== 2'd1 || score !== 8'd0) begin
            failures++;
            $display("FAIL press_latency state=%0d score=%0d exp 1 0", game_state, score);
        end
        steps(2);
        move_btn = 1'b0;
        steps(10);
        checks++;
        if (game_state !== 2'd1) begin
            failures++;
            $display("FAIL single_press state=%0d exp 1", game_state);
        end
    endtask

    task automatic test_scroll();
        press_btn();
        checks++;
        if (game_state !== 2'd2 || scroll_offset !== 5'd0) begin
            failures++;
            $display("FAIL scroll_entry state=%0d off=%0d exp 2 0", game_state, scroll_offset);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(1'b0);
            checks++;
            if (scroll_offset !== 5'((i * 4) % 32)) begin
                failures++;
                $display("FAIL scroll_offset step=%0d got=%0d exp=%0d", i, scroll_offset, (i * 4) % 32);
            end
            if (i < 8) begin
                checks++;
                if (game_state !== 2'd2 || lane_shift !== 1'b0) begin
                    failures++;
                    $display("FAIL scroll_mid step=%0d state=%0d shift=%0d exp 2 0", i, game_state, lane_shift);
                end
            end
            if (i == 4) begin
                press_btn();
                checks++;
                if (game_state !== 2'd2 || scroll_offset !== 5'd16) begin
                    failures++;
                    $display("FAIL press_in_scroll state=%0d off=%0d exp 2 16", game_state, scroll_offset);
                end
            end
        end
        checks++;
        if (game_state !== 2'd1 || lane_shift !== 1'b1 || score !== 8'd1 || lane_seed !== 8'h4A) begin
            failures++;
            $display("FAIL scroll_done state=%0d shift=%0d score=%0d seed=%h exp 1 1 1 4a",
                     game_state, lane_shift, score, lane_seed);
        end
        step();
        checks++;
        if (lane_shift !== 1'b0 || speed !== 2'd0) begin
            failures++;
            $display("FAIL shift_pulse_width shift=%0d speed=%0d exp 0 0", lane_shift, speed);
        end
        seed_m = 8'h4A;
    endtask

    task automatic test_collision();
        move_btn = 1'b1;
        steps(7);
        frame_tick = 1'b1;
        collision  = 1'b1;
        step();
        frame_tick = 1'b0;
        collision  = 1'b0;
        checks++;
        if (game_state !== 2'd3) begin
            failures++;
            $display("FAIL collision_priority state=%0d exp 3", game_state);
        end
        move_btn = 1'b0;
        steps(10);
    endtask

    task automatic test_dead_timeout();
        press_btn();
        checks++;
        if (game_state !== 2'd3 || score !== 8'd1) begin
            failures++;
            $display("FAIL dead_press_ignored state=%0d score=%0d exp 3 1", game_state, score);
        end
        tick(1'b0);
        tick(1'b0);
        checks++;
        if (game_state !== 2'd3) begin
            failures++;
            $display("FAIL dead_hold state=%0d exp 3", game_state);
        end
        tick(1'b0);
        checks++;
        if (game_state !== 2'd0 || score !== 8'd1) begin
            failures++;
            $display("FAIL dead_exit state=%0d score=%0d exp 0 1", game_state, score);
        end
        press_btn();
        checks++;
        if (game_state !== 2'd1 || score !== 8'd0) begin
            failures++;
            $display("FAIL restart state=%0d score=%0d exp 1 0", game_state, score);
        end
        press_btn();
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (game_state !== 2'd3 || scroll_offset !== 5'd12 || lane_shift !== 1'b0 || lane_seed !== seed_m) begin
            failures++;
            $display("FAIL scroll_collision state=%0d off=%0d shift=%0d seed=%h exp 3 12 0 %h",
                     game_state, scroll_offset, lane_shift, lane_seed, seed_m);
        end
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        checks++;
        if (game_state !== 2'd0 || scroll_offset !== 5'd12) begin
            failures++;
            $display("FAIL dead_exit2 state=%0d off=%0d exp 0 12", game_state, scroll_offset);
        end
    endtask

    task automatic test_saturation();
        int exp_score;
        int prev_score;
        press_btn();
        prev_score = 0;
        for (int n = 1; n <= 260; n++) begin
            press_btn();
            for (int t = 0; t < 8; t++) tick(1'b0);
            seed_m    = model_lfsr(seed_m);
            exp_score = (n > 255) ? 255 : n;
            checks++;
            if (score !== 8'(exp_score) || lane_shift !== 1'b1 || lane_seed !== seed_m ||
                speed !== model_speed(prev_score)) begin
                failures++;
                $display("FAIL sat_scroll n=%0d score=%0d shift=%0d seed=%h speed=%0d exp %0d 1 %h %0d",
                         n, score, lane_shift, lane_seed, speed, exp_score, seed_m, model_speed(prev_score));
            end
            step();
            checks++;
            if (speed !== model_speed(exp_score) || game_state !== 2'd1) begin
                failures++;
                $display("FAIL sat_speed n=%0d speed=%0d state=%0d exp %0d 1",
                         n, speed, game_state, model_speed(exp_score));
            end
            prev_score = exp_score;
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_scroll();
        test_collision();
        test_dead_timeout();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
